// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: FSM state, reset PC and base RV32I opcodes.
// No logic; latency and backpressure do not apply.
package riscv_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch and imem.
// Request held until ack; imem stalls fetch simply by withholding ack.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset to RESET_VAL.
// One-cycle latency; holds its value whenever en is low.
module flopenr #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: BOOT -> FETCH -> ISSUE -> FETCH, HALT on misaligned target.
// Ack-to-valid latency 1 cycle; imem stalls via ack, execute stalls by withholding retire.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_unit_if.master           imem,
  output logic                   instr_valid,
  output logic [31:0]            instr,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic [6:0]             op,
  output logic [2:0]             funct3,
  output logic                   funct7b5,
  input  logic                   retire,
  input  logic                   PCSrc,
  input  logic [31:0]            PCTarget,
  output logic                   misalign_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  fetch_state_t state, state_nxt;

  logic        retire_now;
  logic        bad_target;
  logic        pc_en;
  logic [31:0] pc_nxt;
  logic        ack_now;

  assign retire_now = (state == ISSUE) && retire;
  assign bad_target = PCSrc && !is_word_aligned(PCTarget);
  assign pc_en      = retire_now && !bad_target;
  assign pc_plus4   = pc + 32'd4;
  assign pc_nxt     = PCSrc ? PCTarget : pc_plus4;
  assign ack_now    = (state == FETCH) && imem.imem_ack;

  flopenr #(
    .WIDTH     (32),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .d     (pc_nxt),
    .q     (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;
    case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) state_nxt = ISSUE;
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (retire) state_nxt = bad_target ? HALT : FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  assign imem.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr        <= '0;
      misalign_err <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      if (ack_now) instr <= imem.imem_rdata;
      if (retire_now && bad_target) misalign_err <= 1'b1;
      // saturate rather than wrap so a long stall never reads as a short one
      if ((state == FETCH) && !imem.imem_ack && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign op       = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected issues, a negedge monitor scores them.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr, pc, pc_plus4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        retire, PCSrc;
  logic [31:0] PCTarget;
  logic        misalign_err;
  logic [15:0] stall_cnt;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .STALL_CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem         (imem),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .op           (op),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .retire       (retire),
    .PCSrc        (PCSrc),
    .PCTarget     (PCTarget),
    .misalign_err (misalign_err),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   seen_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] i, input logic [31:0] p, input logic [31:0] p4,
                              input logic [6:0] o, input logic [2:0] f3, input logic f7);
    exp_t e;
    e.instr = i; e.pc = p; e.pc4 = p4; e.op = o; e.f3 = f3; e.f7 = f7;
    return e;
  endfunction

  // Monitor: score each new issue (rising edge of instr_valid) against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (instr_valid && !seen_valid) begin
        seen_valid = 1'b1;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue actual instr=0x%08h pc=0x%08h required no issue", instr, pc);
        end else begin
          e = sbq.pop_front();
          chk("sb_instr", instr, e.instr);
          chk("sb_pc", pc, e.pc);
          chk("sb_pc_plus4", pc_plus4, e.pc4);
          chk("sb_op", {25'd0, op}, {25'd0, e.op});
          chk("sb_funct3", {29'd0, funct3}, {29'd0, e.f3});
          chk("sb_funct7b5", {31'd0, funct7b5}, {31'd0, e.f7});
        end
      end else if (!instr_valid) begin
        seen_valid = 1'b0;
      end
    end
  end

  // Wait for the request, hold off ack for dly cycles, then ack with e.instr.
  task automatic do_fetch(input int dly, input exp_t e);
    int n = 0;
    bit stable = 1'b1;
    while (!imem.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req_seen", {31'd0, imem.imem_req}, 32'd1);
    chk("fetch_addr", imem.imem_addr, e.pc);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (imem.imem_req !== 1'b1 || imem.imem_addr !== e.pc) stable = 1'b0;
    end
    chk("fetch_hold_stable", {31'd0, stable}, 32'd1);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = e.instr;
    sbq.push_back(e);
    @(negedge clk);
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'hDEAD_BEEF;
    chk("issue_latency_valid", {31'd0, instr_valid}, 32'd1);
    chk("issue_req_low", {31'd0, imem.imem_req}, 32'd0);
  endtask

  task automatic do_retire(input logic src, input logic [31:0] tgt);
    retire   = 1'b1;
    PCSrc    = src;
    PCTarget = tgt;
    @(negedge clk);
    retire   = 1'b0;
    PCSrc    = 1'b0;
    PCTarget = 32'h0BAD_0001;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_req, saw_valid;
    reset           = 1'b1;
    retire          = 1'b0;
    PCSrc           = 1'b0;
    PCTarget        = 32'h0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    reset = 1'b0;

    // first fetch acked in its first FETCH cycle (addi x1,x0,5)
    do_fetch(0, mk(32'h0050_0093, 32'h0, 32'h4, 7'h13, 3'd0, 1'b0));
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    imem.imem_ack   = 1'b0;
    chk("ack_ignored_in_issue", instr, 32'h0050_0093);
    chk("issue_still_valid", {31'd0, instr_valid}, 32'd1);
    chk("stall_after_first", {16'd0, stall_cnt}, 32'd0);
    do_retire(1'b0, 32'h0);

    // ack delayed three cycles (sra: funct3=5, funct7b5=1)
    do_fetch(3, mk(32'h40A5_D533, 32'h4, 32'h8, 7'h33, 3'd5, 1'b1));
    chk("stall_after_delay3", {16'd0, stall_cnt}, 32'd3);
    do_retire(1'b1, 32'h0000_0100);

    // taken branch to 0x100
    do_fetch(1, mk(32'h0020_8663, 32'h100, 32'h104, 7'h63, 3'd0, 1'b0));
    chk("pc_plus4_after_branch", pc_plus4, 32'h104);
    do_retire(1'b1, 32'hFFFF_FFFC);

    // top of address space, then sequential wrap to zero
    do_fetch(0, mk(32'h0000_1013, 32'hFFFF_FFFC, 32'h0, 7'h13, 3'd1, 1'b0));
    do_retire(1'b0, 32'h0);
    do_fetch(2, mk(32'h4000_0033, 32'h0, 32'h4, 7'h33, 3'd0, 1'b1));
    chk("stall_cumulative", {16'd0, stall_cnt}, 32'd6);

    // misaligned target -> HALT
    do_retire(1'b1, 32'h0000_0102);
    chk("halt_misalign", {31'd0, misalign_err}, 32'd1);
    chk("halt_req", {31'd0, imem.imem_req}, 32'd0);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_pc_unchanged", pc, 32'h0);
    saw_req   = 1'b0;
    saw_valid = 1'b0;
    imem.imem_ack = 1'b1;
    retire        = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (imem.imem_req !== 1'b0) saw_req = 1'b1;
      if (instr_valid !== 1'b0) saw_valid = 1'b1;
    end
    imem.imem_ack = 1'b0;
    retire        = 1'b0;
    chk("halt_no_req", {31'd0, saw_req}, 32'd0);
    chk("halt_no_valid", {31'd0, saw_valid}, 32'd0);

    // reset out of HALT
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst2_misalign", {31'd0, misalign_err}, 32'd0);
    chk("rst2_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst2_pc", pc, 32'h0);
    reset = 1'b0;
    do_fetch(1, mk(32'h0010_0113, 32'h0, 32'h4, 7'h13, 3'd0, 1'b0));
    chk("stall_after_rst2", {16'd0, stall_cnt}, 32'd1);
    do_retire(1'b1, 32'h0000_0200);

    // reset mid-FETCH, stray ack during BOOT
    chk("midfetch_addr", imem.imem_addr, 32'h200);
    chk("midfetch_req", {31'd0, imem.imem_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset           = 1'b0;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    chk("boot_req", {31'd0, imem.imem_req}, 32'd0);
    chk("boot_valid", {31'd0, instr_valid}, 32'd0);
    chk("boot_instr_cleared", instr, 32'h0);
    chk("boot_pc", pc, 32'h0);
    @(negedge clk);
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'h0;
    chk("stray_ack_ignored", instr, 32'h0);
    chk("refetch_valid_low", {31'd0, instr_valid}, 32'd0);
    do_fetch(0, mk(32'h00C0_0193, 32'h0, 32'h4, 7'h13, 3'd0, 1'b0));
    do_retire(1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: STALL_CNT_W, default 16, width of the fetch-stall counter.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory request.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_ack  input  1  imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr_valid  output  1  instr/pc/decoded fields valid for execute.
REQ-010 instr  output  32  held instruction word.
REQ-011 pc  output  32  address of the held instruction.
REQ-012 pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-013 op  output  7  instr[6:0].
REQ-014 funct3  output  3  instr[14:12].
REQ-015 funct7b5  output  1  instr[30].
REQ-016 retire  input  1  execute has consumed the held instruction; PCSrc and PCTarget are valid.
REQ-017 PCSrc  input  1  1 = take PCTarget; 0 = take pc_plus4.
REQ-018 PCTarget  input  32  branch/jump target.
REQ-019 misalign_err  output  1  sticky flag: a taken target was not word-aligned.
REQ-020 stall_cnt  output  STALL_CNT_W  saturating count of FETCH cycles without imem_ack.

Function
REQ-021 FSM states: BOOT, FETCH, ISSUE, HALT; fetch_state_t is the state type.
REQ-022 BOOT lasts exactly one cycle; imem_req=0; next state FETCH.
REQ-023 FETCH: imem_req=1; imem_addr=pc; both held stable until imem_ack.
REQ-024 FETCH with imem_ack=1: capture imem_rdata into instr; go to ISSUE next cycle. An ack in the same cycle as the first req is legal.
REQ-025 FETCH with imem_ack=0: stay in FETCH; stall_cnt increments and saturates at all-ones.
REQ-026 ISSUE: instr_valid=1 and imem_req=0; instr, pc, op, funct3, funct7b5 held constant.
REQ-027 ISSUE with retire=1 and PCSrc=0: pc <= pc+4 (0xFFFF_FFFC wraps to 0x0000_0000); go to FETCH.
REQ-028 ISSUE with retire=1, PCSrc=1, PCTarget[1:0]==0: pc <= PCTarget; go to FETCH.
REQ-029 ISSUE with retire=1, PCSrc=1, PCTarget[1:0]!=0: misalign_err <= 1; pc unchanged; go to HALT.
REQ-030 HALT: imem_req=0 and instr_valid=0; the block stays in HALT until reset.
REQ-031 imem_ack is ignored outside FETCH; retire is ignored outside ISSUE.
REQ-032 Fetch latency is 1 cycle from ack to instr_valid; the minimum steady-state rate is one instruction per 2 cycles.
REQ-033 op, funct3 and funct7b5 are combinational slices of the instr register, not separately registered.

Reset
REQ-034 reset=1 at a clock edge forces: state=BOOT, pc=RESET_PC, instr=0, misalign_err=0, stall_cnt=0.
REQ-035 While in BOOT after reset: imem_req=0 and instr_valid=0.
REQ-036 Reset mid-FETCH abandons the request; imem must drop any pending transaction on the same reset.
REQ-037 Reset mid-ISSUE discards the held instruction.

Structure
REQ-038 fetch_state_t enum, RESET_PC default and the opcode constants go in shared package riscv_pkg.
REQ-039 The PC is an instance of the enabled, resettable register sub-module flopenr (WIDTH=32); the enable is the retire/PC-update condition.
REQ-040 All other logic is inline.

Verification
REQ-041 Reset, then ack in the first FETCH cycle with rdata=0x00500093 -> imem_addr=0x0; instr_valid=1 one cycle later; op=0x13, funct3=0.
REQ-042 Ack delayed 3 cycles -> imem_req and imem_addr stable for 4 cycles; stall_cnt=3.
REQ-043 Retire with PCSrc=1, PCTarget=0x100 -> next imem_addr=0x100; pc_plus4=0x104 once the new instruction issues.
REQ-044 pc=0xFFFF_FFFC, retire with PCSrc=0 -> next imem_addr=0x0.
REQ-045 Retire with PCSrc=1, PCTarget=0x102 -> misalign_err=1, HALT, no further imem_req; reset clears the flag and fetches from RESET_PC.
REQ-046 Reset asserted mid-FETCH with a later stray ack -> BOOT, the stray ack is ignored, and the next fetch is from RESET_PC.
